// File: rtl/ccip_avmm_pkg.sv
// Shared types for the CCI-P <-> Avalon-MM shim: MMIO channel subsets, command and tag records.
package ccip_avmm_pkg;
    localparam int CCIP_AVMM_MMIO_ADDR_WIDTH = 18;
    localparam int CCIP_AVMM_MMIO_DATA_WIDTH = 64;

    localparam logic [1:0] MMIO_LEN_4B  = 2'd0;
    localparam logic [1:0] MMIO_LEN_8B  = 2'd1;
    localparam logic [1:0] MMIO_LEN_64B = 2'd2;

    // Only the MMIO-relevant fields of the CCI-P channels are carried here.
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic                mmioRdValid;
        logic                mmioWrValid;
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic                mmioRdValid;
        t_ccip_c2_RspMmioHdr hdr;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic        is_read;
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_ccip_avmm_mmio_cmd;

    typedef struct packed {
        logic [8:0] tid;
        logic [1:0] len;
        logic       dw_sel;
    } t_ccip_avmm_mmio_tag;
endpackage

// File: rtl/ccip_avmm_sc_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes into a full FIFO are dropped.
module ccip_avmm_sc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ccip_mmio_avmm_responder.sv
// Replays host MMIO requests as Avalon-MM master commands and returns read data on c2tx.
// Define CCIP_MMIO_AVMM_ERR_EN to build the sticky error flag.
module ccip_mmio_avmm_responder
    import ccip_avmm_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH = 64,
    parameter int TAG_FIFO_DEPTH = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  t_if_ccip_c0_Rx                       c0rx,
    output t_if_ccip_c2_Tx                       c2tx,
    output logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] avmm_address,
    output logic                                 avmm_read,
    output logic                                 avmm_write,
    output logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0] avmm_writedata,
    output logic [7:0]                           avmm_byteenable,
    input  logic                                 avmm_waitrequest,
    input  logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0] avmm_readdata,
    input  logic                                 avmm_readdatavalid,
    output logic                                 err_sticky
);
    localparam int CMD_W = $bits(t_ccip_avmm_mmio_cmd);
    localparam int TAG_W = $bits(t_ccip_avmm_mmio_tag);

    logic                in_vld, in_bad;
    logic                cap_vld;
    t_ccip_avmm_mmio_cmd cap_cmd, head;
    t_ccip_avmm_mmio_tag tag_din, tag_head;
    logic                req_full, req_empty, req_pop;
    logic                tag_full, tag_empty, tag_push, rsp_take;
    logic                head_vld, head_4b;
    logic [$clog2(REQ_FIFO_DEPTH):0] req_count_unused;
    logic [$clog2(TAG_FIFO_DEPTH):0] tag_count_unused;

    // 64B MMIO is not supported by the CSR space; such requests never reach the FIFO.
    assign in_vld = c0rx.mmioRdValid | c0rx.mmioWrValid;
    assign in_bad = in_vld & (c0rx.hdr.length == MMIO_LEN_64B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vld <= 1'b0;
            cap_cmd <= '0;
        end else begin
            cap_vld <= in_vld & ~in_bad;
            cap_cmd <= '{is_read: c0rx.mmioRdValid, addr: c0rx.hdr.address,
                         len: c0rx.hdr.length, tid: c0rx.hdr.tid, data: c0rx.data};
        end
    end

    ccip_avmm_sc_fifo #(.WIDTH(CMD_W), .DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap_vld),
        .din   (cap_cmd),
        .pop   (req_pop),
        .dout  (head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count_unused)
    );

    // Outputs come straight from the FIFO head, so they stay put while the slave stalls.
    // A read never drops once raised: tag occupancy only grows on read acceptance.
    assign head_vld        = ~req_empty;
    assign head_4b         = (head.len == MMIO_LEN_4B);
    assign avmm_read       = head_vld & head.is_read & ~tag_full;
    assign avmm_write      = head_vld & ~head.is_read;
    assign avmm_address    = head_vld ? {head.addr[15:1], 3'b000} : '0;
    assign avmm_byteenable = ~head_vld ? 8'h00 :
                             head_4b ? (head.addr[0] ? 8'hF0 : 8'h0F) : 8'hFF;
    assign avmm_writedata  = ~head_vld ? '0 :
                             head_4b ? {head.data[31:0], head.data[31:0]} : head.data;
    assign req_pop         = (avmm_read | avmm_write) & ~avmm_waitrequest;
    assign tag_push        = avmm_read & ~avmm_waitrequest;
    assign tag_din         = '{tid: head.tid, len: head.len, dw_sel: head.addr[0]};

    ccip_avmm_sc_fifo #(.WIDTH(TAG_W), .DEPTH(TAG_FIFO_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tag_push),
        .din   (tag_din),
        .pop   (rsp_take),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count_unused)
    );

    assign rsp_take = avmm_readdatavalid & ~tag_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c2tx <= '0;
        end else begin
            c2tx.mmioRdValid <= rsp_take;
            if (rsp_take) begin
                c2tx.hdr.tid <= tag_head.tid;
                if (tag_head.len == MMIO_LEN_4B)
                    c2tx.data <= {32'h0, tag_head.dw_sel ? avmm_readdata[63:32] : avmm_readdata[31:0]};
                else
                    c2tx.data <= avmm_readdata;
            end
        end
    end

`ifdef CCIP_MMIO_AVMM_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_sticky <= 1'b0;
        else if (in_bad | (cap_vld & req_full) | (avmm_readdatavalid & tag_empty))
            err_sticky <= 1'b1;
    end
`else
    assign err_sticky = 1'b0;
`endif
endmodule
